// File: rtl/bf2_ctrl_pkg.sv
// Shared types and default sizing for the radix-2 butterfly pipeline sequencer and the
// downstream logic that consumes its block/frame tags.
package bf2_ctrl_pkg;

    localparam int unsigned BLOCKS_PER_FRAME_DEF = 32;
    localparam int unsigned NUM_STAGES_DEF       = 3;
    localparam int unsigned FRM_W_DEF            = 16;
    // Tags carry the widest supported block index; narrower configurations zero-extend.
    localparam int unsigned BLK_MAX_W            = 16;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } bf2_state_e;

    typedef struct packed {
        logic [BLK_MAX_W-1:0] blk;
        logic                 sof;
        logic                 eof;
    } bf2_tag_t;

endpackage

// File: rtl/bf2_pipe_ctrl_if.sv
// Sample-bundle handshake between the input buffer, the butterfly sequencer and the
// post-butterfly twiddle/reorder stage.
interface bf2_pipe_ctrl_if #(
    parameter int unsigned BLK_W = 5
);

    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [BLK_W-1:0] out_blk;
    logic             out_sof;
    logic             out_eof;

    modport master (
        input  in_valid,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_blk,
        output out_sof,
        output out_eof
    );

    modport slave (
        output in_valid,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_blk,
        input  out_sof,
        input  out_eof
    );

endinterface

// File: rtl/bf2_tag_pipe.sv
// Valid + tag shift register sharing one advance strobe; everything holds while advance is
// low, so the last stage stays stable under backpressure.
module bf2_tag_pipe #(
    parameter int unsigned NumStages = 3,
    parameter int unsigned TagW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 advance,
    input  logic                 in_valid,
    input  logic [TagW-1:0]      in_tag,
    output logic [NumStages-1:0] valid,
    output logic [TagW-1:0]      out_tag
);

    logic [NumStages-1:0]           valid_q;
    logic [NumStages-1:0][TagW-1:0] tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else if (advance) begin
            valid_q[0] <= in_valid;
            tag_q[0]   <= in_tag;
            for (int k = 1; k < NumStages; k++) begin
                valid_q[k] <= valid_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    assign valid   = valid_q;
    assign out_tag = tag_q[NumStages-1];

endmodule

// File: rtl/bf2_pipe_ctrl.sv
// Sequencer for a chain of registered butterfly stages: frame/block counting, bubble-gated
// per-stage enables, global output backpressure and block/frame tags riding with the data.
module bf2_pipe_ctrl
    import bf2_ctrl_pkg::*;
#(
    parameter int unsigned BLOCKS_PER_FRAME = BLOCKS_PER_FRAME_DEF,
    parameter int unsigned NUM_STAGES       = NUM_STAGES_DEF,
    parameter int unsigned FRM_W            = FRM_W_DEF,
    parameter int unsigned BLK_W            = $clog2(BLOCKS_PER_FRAME)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRM_W-1:0]      num_frames,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_err,
    bf2_pipe_ctrl_if.master       bus
);

    localparam logic [BLK_W-1:0] LastBlk  = BLK_W'(BLOCKS_PER_FRAME - 1);
    localparam logic [FRM_W-1:0] OneFrame = FRM_W'(1);

    bf2_state_e       state_q, state_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic [FRM_W-1:0] frames_left_q, frames_left_d;
    logic             frame_err_q, frame_err_d;

    logic                  advance;
    logic                  in_ready;
    logic                  accept;
    logic                  cnt_eof;
    logic [NUM_STAGES-1:0] v;
    bf2_tag_t              in_tag;
    bf2_tag_t              out_tag;

    // A full last stage that is not being taken freezes the whole chain.
    assign advance  = ~v[NUM_STAGES-1] | bus.out_ready;
    assign in_ready = advance & (state_q == StRun);
    assign accept   = bus.in_valid & in_ready;
    assign cnt_eof  = (blk_cnt_q == LastBlk);

    always_comb begin
        stage_en    = '0;
        stage_en[0] = advance & accept;
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_en[k] = advance & v[k-1];
        end
    end

    always_comb begin
        in_tag     = '0;
        in_tag.blk = BLK_MAX_W'(blk_cnt_q);
        in_tag.sof = (blk_cnt_q == '0);
        in_tag.eof = cnt_eof;
    end

    bf2_tag_pipe #(
        .NumStages (NUM_STAGES),
        .TagW      ($bits(bf2_tag_t))
    ) u_tag_pipe (
        .clk      (clk),
        .rst      (rst),
        .advance  (advance),
        .in_valid (accept),
        .in_tag   (in_tag),
        .valid    (v),
        .out_tag  (out_tag)
    );

    always_comb begin
        state_d       = state_q;
        blk_cnt_d     = blk_cnt_q;
        frames_left_d = frames_left_q;
        frame_err_d   = frame_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d       = StRun;
                    blk_cnt_d     = '0;
                    frames_left_d = (num_frames == '0) ? OneFrame : num_frames;
                    frame_err_d   = 1'b0;
                end
            end
            StRun: begin
                if (accept) begin
                    // The counter owns framing; in_last only feeds the error flag.
                    blk_cnt_d = cnt_eof ? '0 : blk_cnt_q + 1'b1;
                    if (bus.in_last != cnt_eof) begin
                        frame_err_d = 1'b1;
                    end
                    if (cnt_eof) begin
                        frames_left_d = frames_left_q - OneFrame;
                        if (frames_left_q == OneFrame) begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (v == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            blk_cnt_q     <= '0;
            frames_left_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_cnt_q     <= blk_cnt_d;
            frames_left_q <= frames_left_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = v[NUM_STAGES-1];
    assign bus.out_blk   = BLK_W'(out_tag.blk);
    assign bus.out_sof   = out_tag.sof;
    assign bus.out_eof   = out_tag.eof;

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign frame_err = frame_err_q;

endmodule
